// File: rtl/demux_lane_collect_pkg.sv
// State encoding and default lane geometry shared by demux_lane_collect
// and its bench.
package demux_lane_collect_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    localparam int DEF_NR_LANE = 4;
    localparam int DEF_LANE_W  = 2;
    localparam int DEF_KEY_W   = 2;
    localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/demux_lane_collect_if.sv
// Keyed beat input and assembled word output of demux_lane_collect.
// The slave side is the collector, the master side the surrounding logic.
interface demux_lane_collect_if #(
    parameter int NR_LANE = demux_lane_collect_pkg::DEF_NR_LANE,
    parameter int LANE_W  = demux_lane_collect_pkg::DEF_LANE_W,
    parameter int KEY_W   = demux_lane_collect_pkg::DEF_KEY_W
);
    logic                      in_valid;
    logic                      in_ready;
    logic [KEY_W-1:0]          in_key;
    logic [LANE_W-1:0]         in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [NR_LANE*LANE_W-1:0] out_word;
    logic [NR_LANE-1:0]        out_mask;
    logic                      err_key;

    modport slave (
        input  in_valid, in_key, in_data, out_ready,
        output in_ready, out_valid, out_word, out_mask, err_key
    );

    modport master (
        output in_valid, in_key, in_data, out_ready,
        input  in_ready, out_valid, out_word, out_mask, err_key
    );
endinterface

// File: rtl/demux_lane_collect_lane_reg.sv
// One lane slot: payload register plus a written flag, both cleared
// synchronously; clear wins over write.
module demux_lane_reg #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_we,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic         o_written
);
    logic [W-1:0] r_q;
    logic         r_written;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q       <= '0;
            r_written <= 1'b0;
        end else if (i_we) begin
            r_q       <= i_d;
            r_written <= 1'b1;
        end
    end

    assign o_q       = r_q;
    assign o_written = r_written;
endmodule

// File: rtl/demux_lane_collect.sv
// Steers keyed lane beats into a word and hands it out once every lane
// is written. DEMUX_TIMEOUT_EN adds an idle timer that flushes a partial frame.
module demux_lane_collect
    import demux_lane_collect_pkg::*;
#(
    parameter int NR_LANE = DEF_NR_LANE,
    parameter int LANE_W  = DEF_LANE_W,
    parameter int KEY_W   = DEF_KEY_W
`ifdef DEMUX_TIMEOUT_EN
    ,
    parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
    input  logic                clk,
    input  logic                rst,
    demux_lane_collect_if.slave bus
);
    state_t                    r_state;
    state_t                    w_state_nxt;
    state_t                    w_frame_st;
    logic                      w_out_valid;
    logic                      w_acc;
    logic                      w_hs;
    logic                      w_clr;
    logic                      w_in_range;
    logic                      w_expire;
    logic                      r_err;
    logic [NR_LANE-1:0]        w_we;
    logic [NR_LANE-1:0]        w_mask;
    logic [NR_LANE-1:0]        w_mask_nxt;
    logic [NR_LANE*LANE_W-1:0] w_word;

    assign w_acc      = bus.in_valid && !w_out_valid;
    assign w_hs       = w_out_valid && bus.out_ready;
    assign w_clr      = rst || w_hs;
    assign w_in_range = 32'(bus.in_key) < NR_LANE;

    for (genvar k = 0; k < NR_LANE; k++) begin : g_lane
        assign w_we[k] = w_acc && w_in_range && (32'(bus.in_key) == k);

        demux_lane_reg #(.W(LANE_W)) u_lane (
            .clk       (clk),
            .i_clr     (w_clr),
            .i_we      (w_we[k]),
            .i_d       (bus.in_data),
            .o_q       (w_word[LANE_W*k +: LANE_W]),
            .o_written (w_mask[k])
        );
    end

    // Where an accepted beat leaves the frame; out-of-range keys leave it as is.
    assign w_mask_nxt = w_mask | w_we;
    assign w_frame_st = (&w_mask_nxt) ? ST_FULL :
                        (|w_mask_nxt) ? ST_COLLECT : ST_IDLE;

`ifdef DEMUX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_timer;

    always_ff @(posedge clk) begin
        if (rst || r_state != ST_COLLECT || w_acc)
            r_timer <= '0;
        else
            r_timer <= r_timer + TW'(1);
    end

    assign w_expire = (r_state == ST_COLLECT) && !w_acc &&
                      (r_timer == TW'(TIMEOUT - 1));
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:
                if (w_acc) w_state_nxt = w_frame_st;
            ST_COLLECT:
                if (w_acc)         w_state_nxt = w_frame_st;
                else if (w_expire) w_state_nxt = ST_FULL;
            ST_FULL:
                if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:
                w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_out_valid = (r_state == ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_acc && !w_in_range)
            r_err <= 1'b1;
    end

    assign bus.in_ready  = !w_out_valid;
    assign bus.out_valid = w_out_valid;
    assign bus.out_word  = w_word;
    assign bus.out_mask  = w_mask;
    assign bus.err_key   = r_err;
endmodule

// File: tb/tb_demux_lane_collect.sv
// Directed plus random bench for demux_lane_collect (KEY_W=3 so that
// out-of-range keys exist), checked against a lane-array model.
module tb_demux_lane_collect;
    localparam int NL = 4;
    localparam int LW = 2;
    localparam int KW = 3;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    demux_lane_collect_if #(.NR_LANE(NL), .LANE_W(LW), .KEY_W(KW)) bus ();

    demux_lane_collect #(.NR_LANE(NL), .LANE_W(LW), .KEY_W(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_mis = 0;

    logic [LW-1:0] m_lane [NL];
    logic [NL-1:0] m_mask;
    bit            m_full;
    bit            m_err;
    int            m_idle;

    function automatic logic [NL*LW-1:0] m_word();
        logic [NL*LW-1:0] w;
        w = '0;
        for (int i = 0; i < NL; i++) w[i*LW +: LW] = m_lane[i];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < NL; i++) m_lane[i] = '0;
        m_mask = '0;
        m_full = 1'b0;
        m_idle = 0;
    endtask

    // Advance the model by one edge from the current inputs, clock, compare.
    task automatic cycle();
        int k;
        k = int'(bus.in_key);
        if (rst) begin
            m_clear();
            m_err = 1'b0;
        end else if (m_full) begin
            if (bus.out_ready) m_clear();
        end else if (bus.in_valid) begin
            if (k < NL) begin
                m_lane[k] = bus.in_data;
                m_mask[k] = 1'b1;
            end else begin
                m_err = 1'b1;
            end
            m_idle = 0;
            if (&m_mask) m_full = 1'b1;
        end else if (m_mask != '0) begin
            m_idle++;
`ifdef DEMUX_TIMEOUT_EN
            if (m_idle == TO) m_full = 1'b1;
`endif
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_full));
        chk("in_ready", 32'(bus.in_ready), 32'(!m_full));
        chk("out_word", 32'(bus.out_word), 32'(m_word()));
        chk("out_mask", 32'(bus.out_mask), 32'(m_mask));
        chk("err_key", 32'(bus.err_key), 32'(m_err));
    endtask

    task automatic beat(input int key, input int data, input bit ordy);
        bus.in_valid  = 1'b1;
        bus.in_key    = KW'(key);
        bus.in_data   = LW'(data);
        bus.out_ready = ordy;
        cycle();
        bus.in_valid  = 1'b0;
    endtask

    task automatic idle(input int n, input bit ordy);
        bus.in_valid  = 1'b0;
        bus.out_ready = ordy;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [NL*LW-1:0] held;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_key    = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        m_clear();
        m_err = 1'b0;
        idle(2, 1'b0);
        chk("rst_word", 32'(bus.out_word), 32'h0);
        rst = 1'b0;

        // Full frame, consumer always ready
        beat(0, 1, 1'b1);
        beat(1, 2, 1'b1);
        beat(2, 3, 1'b1);
        chk("t1_notyet", 32'(bus.out_valid), 32'h0);
        beat(3, 0, 1'b1);
        chk("t1_word", 32'(bus.out_word), 32'h39);
        chk("t1_mask", 32'(bus.out_mask), 32'hF);
        idle(1, 1'b1);
        chk("t1_1cyc", 32'(bus.out_valid), 32'h0);

        // Back-pressure: held word, beats refused
        beat(0, 3, 1'b0);
        beat(1, 1, 1'b0);
        beat(2, 2, 1'b0);
        beat(3, 3, 1'b0);
        held = bus.out_word;
        chk("t2_word", 32'(held), 32'hE7);
        for (int i = 0; i < 5; i++) begin
            beat(0, 0, 1'b0);
            chk("t2_stable", 32'(bus.out_word), 32'hE7);
            chk("t2_noready", 32'(bus.in_ready), 32'h0);
        end
        idle(1, 1'b1);
        chk("t2_cleared", 32'(bus.out_word), 32'h0);
        chk("t2_ready", 32'(bus.in_ready), 32'h1);

        // Duplicate key, last write wins
        beat(2, 1, 1'b0);
        beat(2, 3, 1'b0);
        beat(0, 0, 1'b0);
        beat(1, 0, 1'b0);
        chk("t3_notfull", 32'(bus.out_valid), 32'h0);
        beat(3, 0, 1'b0);
        chk("t3_full", 32'(bus.out_valid), 32'h1);
        chk("t3_word", 32'(bus.out_word), 32'h30);
        idle(1, 1'b1);

        // Out-of-range key is sticky until reset
        beat(5, 1, 1'b1);
        chk("t4_err", 32'(bus.err_key), 32'h1);
        chk("t4_mask", 32'(bus.out_mask), 32'h0);
        beat(1, 2, 1'b1);
        beat(7, 3, 1'b1);
        chk("t4_mask2", 32'(bus.out_mask), 32'h2);
        idle(3, 1'b1);
        chk("t4_sticky", 32'(bus.err_key), 32'h1);
        do_reset();
        chk("t4_rst", 32'(bus.err_key), 32'h0);

        // Reset mid-frame, then a clean frame
        beat(0, 1, 1'b0);
        beat(1, 1, 1'b0);
        do_reset();
        chk("t5_mask", 32'(bus.out_mask), 32'h0);
        beat(3, 2, 1'b0);
        beat(2, 1, 1'b0);
        beat(1, 3, 1'b0);
        beat(0, 2, 1'b0);
        chk("t5_word", 32'(bus.out_word), 32'h9E);
        idle(1, 1'b1);

        // Partial frame left idle
        beat(0, 1, 1'b0);
        beat(1, 2, 1'b0);
        idle(TO - 1, 1'b0);
        chk("t6_early", 32'(bus.out_valid), 32'h0);
        idle(100 - (TO - 1), 1'b0);
`ifdef DEMUX_TIMEOUT_EN
        chk("t6_flush", 32'(bus.out_valid), 32'h1);
        chk("t6_mask", 32'(bus.out_mask), 32'h3);
`else
        chk("t6_wait", 32'(bus.out_valid), 32'h0);
        chk("t6_mask", 32'(bus.out_mask), 32'h3);
`endif
        do_reset();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst           = ($urandom_range(0, 59) == 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_key    = ($urandom_range(0, 11) == 0) ?
                            KW'(4 + $urandom_range(0, 3)) :
                            KW'($urandom_range(0, 3));
            bus.in_data   = LW'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
